// File: rtl/greenfloat_rob_core_pkg.sv
// GreenFloat shared types: op encodings, unit indices, ROB slot layout.
// Latency: n/a (types and one pure helper function only).
// Backpressure: n/a.
package fp16_green_pkg;

  typedef enum logic [1:0] {
    GF_ADD = 2'b00,
    GF_MUL = 2'b10
  } gf_op_e;

  // Index order matches {mode, op[1]} so an accepted op maps straight onto its unit.
  typedef enum logic [1:0] {
    U_ADD32 = 2'd0,
    U_MUL32 = 2'd1,
    U_ADD16 = 2'd2,
    U_MUL16 = 2'd3
  } gf_unit_e;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        mode;
    logic [1:0]  op;
    logic        illegal;
    logic        overflow;
    logic [31:0] result;
  } gf_rob_slot_t;

  function automatic logic [7:0] gf_active_bits(input logic mode);
    return mode ? 8'd16 : 8'd32;
  endfunction

endpackage

// File: rtl/greenfloat_rob_core_fifo.sv
// Sync tag FIFO holding ROB slot indices in issue order for one arithmetic unit.
// Latency: pushed tag visible at pop_dat the cycle after push; pop_dat is combinational.
// Backpressure: none internally; full/empty are reported, and the ROB bounds the fill to DEPTH.
// Ports: clk, rst (sync active-high), push/push_dat, pop/pop_dat, full, empty.
module gf_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] push_dat,
  input  logic             pop,
  output logic [TAG_W-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  logic [TAG_W-1:0] mem [DEPTH];
  logic [TAG_W-1:0] rd_ptr, wr_ptr;
  logic [TAG_W:0]   cnt;

  assign full    = 32'(cnt) == DEPTH;
  assign empty   = cnt == '0;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/greenfloat_rob_core_units.sv
// Pipelined FP add/mul units (generic cores plus FP32/FP16 wrappers).
// Latency: LAT cycles from valid_in to valid_out (add32/add16 2, mul16 3, mul32 4).
// Backpressure: none; units are fire-and-forget, one op per cycle.
// Ports: clk, rst_n (sync active-low), valid_in, a, b, [subtract], valid_out, result, overflow.
// Arithmetic is simplified: subnormals flush to zero, inf/NaN inputs are not special-cased,
// adder truncates, multiplier rounds to nearest-even.
module gf_fp_add #(
  parameter  int EW  = 8,
  parameter  int MW  = 23,
  parameter  int LAT = 2,
  localparam int W   = 1 + EW + MW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         subtract,
  output logic         valid_out,
  output logic [W-1:0] result,
  output logic         overflow
);
  localparam logic [EW:0] EMAX = {1'b0, {EW{1'b1}}};
  localparam logic [EW:0] EONE = (EW+1)'(1);

  logic [W-1:0]       x, y, res_c;
  logic [EW-1:0]      d;
  logic [MW:0]        mx, my;
  logic [MW+1:0]      sum;
  logic [EW:0]        e;
  logic               ov_c;
  logic [LAT-1:0]     vld_q;
  logic [LAT-1:0][W:0] dat_q;

  always_comb begin
    // x is the larger magnitude so the mantissa difference is never negative.
    x = a;
    y = {b[W-1] ^ subtract, b[W-2:0]};
    if (y[W-2:0] > x[W-2:0]) begin
      x = y;
      y = a;
    end
    d   = x[W-2:MW] - y[W-2:MW];
    mx  = (x[W-2:MW] == '0) ? '0 : {1'b1, x[MW-1:0]};
    my  = (y[W-2:MW] == '0 || 32'(d) > MW) ? '0 : ({1'b1, y[MW-1:0]} >> d);
    e   = {1'b0, x[W-2:MW]};
    sum = (x[W-1] == y[W-1]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
    if (sum[MW+1]) begin
      sum = sum >> 1;
      e   = e + EONE;
    end
    for (int i = 0; i <= MW; i++) begin
      if (!sum[MW] && e > EONE) begin
        sum = sum << 1;
        e   = e - EONE;
      end
    end
    ov_c = 1'b0;
    if (!sum[MW]) begin
      res_c = '0;
    end else if (e >= EMAX) begin
      res_c = {x[W-1], EMAX[EW-1:0], {MW{1'b0}}};
      ov_c  = 1'b1;
    end else begin
      res_c = {x[W-1], e[EW-1:0], sum[MW-1:0]};
    end
  end

  // Plain delay line after the combinational datapath; requires LAT >= 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= {vld_q[LAT-2:0], valid_in};
      dat_q <= {dat_q[LAT-2:0], {ov_c, res_c}};
    end
  end

  assign valid_out          = vld_q[LAT-1];
  assign {overflow, result} = dat_q[LAT-1];
endmodule

module gf_fp_mul #(
  parameter  int EW  = 8,
  parameter  int MW  = 23,
  parameter  int LAT = 3,
  localparam int W   = 1 + EW + MW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         valid_out,
  output logic [W-1:0] result,
  output logic         overflow
);
  localparam logic [EW+1:0] BIAS = (EW+2)'((1 << (EW-1)) - 1);

  logic                s, g, st, rnd, ov_c;
  logic [EW-1:0]       ea, eb;
  logic [MW:0]         mx, my;
  logic [2*MW+1:0]     prod;
  logic [EW+1:0]       e;
  logic [MW-1:0]       mant;
  logic [EW+MW:0]      em;
  logic [W-1:0]        res_c;
  logic [LAT-1:0]      vld_q;
  logic [LAT-1:0][W:0] dat_q;

  always_comb begin
    s    = a[W-1] ^ b[W-1];
    ea   = a[W-2:MW];
    eb   = b[W-2:MW];
    mx   = {1'b1, a[MW-1:0]};
    my   = {1'b1, b[MW-1:0]};
    prod = {{(MW+1){1'b0}}, mx} * {{(MW+1){1'b0}}, my};
    // e[EW+1] set means the biased exponent went negative.
    e    = {2'b0, ea} + {2'b0, eb} - BIAS;
    mant = prod[2*MW-1:MW];
    g    = prod[MW-1];
    st   = |prod[MW-2:0];
    if (prod[2*MW+1]) begin
      mant = prod[2*MW:MW+1];
      g    = prod[MW];
      st   = |prod[MW-1:0];
      e    = e + (EW+2)'(1);
    end
    rnd  = g & (st | mant[0]);
    // Rounding carry ripples from mantissa into exponent for free.
    em   = {e[EW:0], mant} + (EW+MW+1)'(rnd);
    ov_c = 1'b0;
    if (ea == '0 || eb == '0 || e[EW+1] || e == '0) begin
      res_c = {s, {(W-1){1'b0}}};
    end else if (em[EW+MW:MW] >= {1'b0, {EW{1'b1}}}) begin
      res_c = {s, {EW{1'b1}}, {MW{1'b0}}};
      ov_c  = 1'b1;
    end else begin
      res_c = {s, em[EW+MW-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= {vld_q[LAT-2:0], valid_in};
      dat_q <= {dat_q[LAT-2:0], {ov_c, res_c}};
    end
  end

  assign valid_out          = vld_q[LAT-1];
  assign {overflow, result} = dat_q[LAT-1];
endmodule

module fp32_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        subtract,
  output logic        valid_out,
  output logic [31:0] result,
  output logic        overflow
);
  gf_fp_add #(.EW(8), .MW(23), .LAT(2)) u_core (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b), .subtract(subtract),
    .valid_out(valid_out), .result(result), .overflow(overflow));
endmodule

module fp32_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        valid_out,
  output logic [31:0] result,
  output logic        overflow
);
  gf_fp_mul #(.EW(8), .MW(23), .LAT(4)) u_core (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b),
    .valid_out(valid_out), .result(result), .overflow(overflow));
endmodule

module fp16_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        subtract,
  output logic        valid_out,
  output logic [15:0] result,
  output logic        overflow
);
  gf_fp_add #(.EW(5), .MW(10), .LAT(2)) u_core (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b), .subtract(subtract),
    .valid_out(valid_out), .result(result), .overflow(overflow));
endmodule

module fp16_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        valid_out,
  output logic [15:0] result,
  output logic        overflow
);
  gf_fp_mul #(.EW(5), .MW(10), .LAT(3)) u_core (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b),
    .valid_out(valid_out), .result(result), .overflow(overflow));
endmodule

// File: rtl/greenfloat_rob_core.sv
// GreenFloat front-end: issues FP32/FP16 add/mul to four units, retires in issue order via a ROB.
// Latency: unit latency L gives out_valid L+1 cycles after accept; illegal ops 1 cycle.
// Backpressure: in_ready drops when all DEPTH slots are allocated; out_* hold while !out_ready.
// Ports: clk, rst; in_valid/in_ready/in_mode/in_op/in_a/in_b; out_valid/out_ready/out_result/
//        out_mode/out_overflow/out_illegal/active_bits; op_count, retire_count, occupancy.
module greenfloat_rob_core
  import fp16_green_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int CNT_W = 16,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_mode,
  output logic             out_overflow,
  output logic             out_illegal,
  output logic [7:0]       active_bits,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] retire_count,
  output logic [TAG_W:0]   occupancy
);
  gf_rob_slot_t     slots [DEPTH];
  gf_rob_slot_t     head_slot;
  logic [TAG_W-1:0] head, tail;
  logic             accept, retire, legal;
  logic [1:0]       sel;
  logic [3:0]       u_vin, u_vout, u_ovf, u_full, u_empty;
  logic [31:0]      u_res [4];
  logic [TAG_W-1:0] u_tag [4];
  logic [31:0]      add32_res, mul32_res;
  logic [15:0]      add16_res, mul16_res;

  // in_ready looks only at registered occupancy: a retire this cycle frees a slot next cycle.
  assign in_ready  = 32'(occupancy) < DEPTH;
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;
  assign legal     = (in_op == GF_ADD) || (in_op == GF_MUL);
  assign sel       = {in_mode, in_op[1]};
  assign head_slot = slots[head];

  always_comb begin
    u_vin = '0;
    if (accept && legal) u_vin[sel] = 1'b1;
  end

  always_comb begin
    u_res[U_ADD32] = add32_res;
    u_res[U_MUL32] = mul32_res;
    u_res[U_ADD16] = {16'b0, add16_res};
    u_res[U_MUL16] = {16'b0, mul16_res};
  end

  fp32_adder u_add32 (
    .clk(clk), .rst_n(~rst), .valid_in(u_vin[U_ADD32]), .a(in_a), .b(in_b), .subtract(1'b0),
    .valid_out(u_vout[U_ADD32]), .result(add32_res), .overflow(u_ovf[U_ADD32]));
  fp32_multiplier u_mul32 (
    .clk(clk), .rst_n(~rst), .valid_in(u_vin[U_MUL32]), .a(in_a), .b(in_b),
    .valid_out(u_vout[U_MUL32]), .result(mul32_res), .overflow(u_ovf[U_MUL32]));
  fp16_adder u_add16 (
    .clk(clk), .rst_n(~rst), .valid_in(u_vin[U_ADD16]), .a(in_a[15:0]), .b(in_b[15:0]),
    .subtract(1'b0), .valid_out(u_vout[U_ADD16]), .result(add16_res), .overflow(u_ovf[U_ADD16]));
  fp16_multiplier u_mul16 (
    .clk(clk), .rst_n(~rst), .valid_in(u_vin[U_MUL16]), .a(in_a[15:0]), .b(in_b[15:0]),
    .valid_out(u_vout[U_MUL16]), .result(mul16_res), .overflow(u_ovf[U_MUL16]));

  // Each unit completes in order, so its FIFO head is always the slot of its next result.
  for (genvar u = 0; u < 4; u++) begin : g_tag
    gf_tag_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo (
      .clk(clk), .rst(rst), .push(u_vin[u]), .push_dat(tail), .pop(u_vout[u]),
      .pop_dat(u_tag[u]), .full(u_full[u]), .empty(u_empty[u]));

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(u_vin[u] && u_full[u]));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(u_vout[u] && u_empty[u]));
  end

  // Retire, completions and accept always touch different slots: the head is already done,
  // completions target pending slots, and tail==head with a retire implies full (no accept).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      head         <= '0;
      tail         <= '0;
      occupancy    <= '0;
      op_count     <= '0;
      retire_count <= '0;
    end else begin
      if (retire) begin
        slots[head]  <= '0;
        head         <= head + 1'b1;
        retire_count <= retire_count + 1'b1;
      end
      for (int u = 0; u < 4; u++) begin
        if (u_vout[u]) begin
          slots[u_tag[u]].done     <= 1'b1;
          slots[u_tag[u]].result   <= u_res[u];
          slots[u_tag[u]].overflow <= u_ovf[u];
        end
      end
      if (accept) begin
        slots[tail] <= '{valid: 1'b1, done: !legal, mode: in_mode, op: in_op,
                         illegal: !legal, overflow: 1'b0, result: '0};
        tail        <= tail + 1'b1;
        op_count    <= op_count + 1'b1;
      end
      if (accept && !retire)      occupancy <= occupancy + 1'b1;
      else if (!accept && retire) occupancy <= occupancy - 1'b1;
    end
  end

  assign out_valid    = head_slot.valid && head_slot.done;
  assign out_result   = head_slot.result;
  assign out_mode     = head_slot.mode;
  assign out_overflow = head_slot.overflow;
  assign out_illegal  = head_slot.illegal;
  assign active_bits  = out_valid ? gf_active_bits(head_slot.mode) : 8'd0;
endmodule
